// File: rtl/msg_event_collector.sv
// Event collector: round-robin arbitration of severity-tagged source events into a FIFO,
// with saturating error/warning counts and a sticky stop request carrying its cause.
module msg_event_collector #(
  parameter int N_SRC  = 4,
  parameter int DEPTH  = 8,
  parameter int CODE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_SRC-1:0]          src_vld,
  input  logic [2*N_SRC-1:0]        src_sev,
  input  logic [CODE_W*N_SRC-1:0]   src_code,
  output logic [N_SRC-1:0]          src_ack,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [$clog2(N_SRC)-1:0]  out_src,
  output logic [1:0]                out_sev,
  output logic [CODE_W-1:0]         out_code,
  input  logic [15:0]               error_limit,
  input  logic [31:0]               timeout,
  input  logic                      soft_clr,
  output logic [15:0]               error_count,
  output logic [15:0]               warn_count,
  output logic                      stop_req,
  output logic [1:0]                stop_cause
);
  localparam int IDX_W = $clog2(N_SRC);
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic {ST_RUN = 1'b0, ST_STOP = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [AW-1:0]      r_wptr, r_rptr;
  logic [AW:0]        r_cnt;
  logic [IDX_W-1:0]   r_mem_src  [DEPTH];
  logic [1:0]         r_mem_sev  [DEPTH];
  logic [CODE_W-1:0]  r_mem_code [DEPTH];
  logic [15:0]        r_err, r_warn;
  logic [31:0]        r_timer;
  logic               r_stop;
  logic [1:0]         r_cause;

  logic               w_grant_vld, w_acc, w_full, w_empty, w_pop;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [1:0]         w_sel_sev;
  logic [CODE_W-1:0]  w_sel_code;
  logic [15:0]        w_err_nxt, w_warn_nxt;
  logic               w_is_err, w_is_warn;
  logic               w_stop_fatal, w_stop_limit, w_stop_to, w_stop_any;
  logic [1:0]         w_cause_nxt;

  // Round-robin search; scanning far-to-near lets the nearest requester win.
  always_comb begin
    logic [IDX_W-1:0] w_idx;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int i = N_SRC; i >= 1; i--) begin
      w_idx = IDX_W'((int'(r_ptr) + i) % N_SRC);
      if (src_vld[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_idx;
      end
    end
  end

  assign w_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_pop   = !w_empty && out_rdy;
  assign w_acc   = (r_state == ST_RUN) && !w_full && !soft_clr && w_grant_vld;

  assign w_sel_sev  = src_sev[2*int'(w_grant_idx) +: 2];
  assign w_sel_code = src_code[CODE_W*int'(w_grant_idx) +: CODE_W];

  // One-hot accept strobe for the granted source.
  always_comb begin
    src_ack = '0;
    if (w_acc) begin
      src_ack[w_grant_idx] = 1'b1;
    end else begin
      src_ack = '0;
    end
  end

  assign w_is_err     = w_sel_sev[1];
  assign w_is_warn    = (w_sel_sev == 2'd1);
  assign w_err_nxt    = (r_err  == 16'hFFFF) ? r_err  : r_err  + 16'd1;
  assign w_warn_nxt   = (r_warn == 16'hFFFF) ? r_warn : r_warn + 16'd1;
  assign w_stop_fatal = w_acc && (w_sel_sev == 2'd3);
  assign w_stop_limit = w_acc && w_is_err && (error_limit != 16'd0) && (w_err_nxt == error_limit);
  assign w_stop_to    = (r_state == ST_RUN) && (timeout != 32'd0) && ((r_timer + 32'd1) == timeout);
  assign w_stop_any   = w_stop_fatal || w_stop_limit || w_stop_to;

  // Cause priority: fatal over limit over timeout.
  always_comb begin
    w_cause_nxt = 2'd0;
    if (w_stop_fatal) begin
      w_cause_nxt = 2'd1;
    end else if (w_stop_limit) begin
      w_cause_nxt = 2'd2;
    end else if (w_stop_to) begin
      w_cause_nxt = 2'd3;
    end else begin
      w_cause_nxt = 2'd0;
    end
  end

  // Next-state logic; soft_clr overrides any stop condition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  w_state_nxt = soft_clr ? ST_RUN : (w_stop_any ? ST_STOP : ST_RUN);
      ST_STOP: w_state_nxt = soft_clr ? ST_RUN : ST_STOP;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // State register and arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_ptr   <= IDX_W'(N_SRC - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_acc) r_ptr <= w_grant_idx;
    end
  end

  // FIFO storage needs no reset: validity is tracked by r_cnt.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_mem_src[r_wptr]  <= w_grant_idx;
      r_mem_sev[r_wptr]  <= w_sel_sev;
      r_mem_code[r_wptr] <= w_sel_code;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_acc) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_acc, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Counters, RUN timer and sticky stop state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err   <= 16'd0;
      r_warn  <= 16'd0;
      r_timer <= 32'd0;
      r_stop  <= 1'b0;
      r_cause <= 2'd0;
    end else if (soft_clr) begin
      r_err   <= 16'd0;
      r_warn  <= 16'd0;
      r_timer <= 32'd0;
      r_stop  <= 1'b0;
      r_cause <= 2'd0;
    end else begin
      if (w_acc && w_is_err)  r_err  <= w_err_nxt;
      if (w_acc && w_is_warn) r_warn <= w_warn_nxt;
      if (r_state == ST_RUN)  r_timer <= r_timer + 32'd1;
      if ((r_state == ST_RUN) && w_stop_any) begin
        r_stop  <= 1'b1;
        r_cause <= w_cause_nxt;
      end
    end
  end

  assign out_vld     = !w_empty;
  assign out_src     = r_mem_src[r_rptr];
  assign out_sev     = r_mem_sev[r_rptr];
  assign out_code    = r_mem_code[r_rptr];
  assign error_count = r_err;
  assign warn_count  = r_warn;
  assign stop_req    = r_stop;
  assign stop_cause  = r_cause;

endmodule
